// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: owner encoding, default widths and strobe-width helper shared by mem_arbiter.
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;
  typedef enum logic {OWN_INST = 1'b0, OWN_DATA = 1'b1} owner_e;
  function automatic int strb_w(input int dw);
    return dw / 8;
  endfunction
endpackage

// File: rtl/mem_arb_grant.sv
// mem_arb_grant: data-over-inst priority decision with optional fetch starvation guard.
// Guard counter is built only when MEM_ARB_STARVE_GUARD_EN is defined.
module mem_arb_grant
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic   clk,
  input  logic   resetn,
  input  logic   inst_req,
  input  logic   data_req,
  input  logic   ready,
  output logic   grant,
  output owner_e winner
);
  logic en_q, en_d;
  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("STARVE_MAX must be at least 1");
  end
  // Enable stays low through reset and for the cycle in which reset is released.
  always_comb en_d = 1'b1;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) en_q <= 1'b0;
    else en_q <= en_d;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CMAX = CW'(STARVE_MAX);
  logic [CW-1:0] cnt_q, cnt_d;
  logic force_inst;
  always_comb begin
    force_inst = inst_req && cnt_q == CMAX;
    winner = data_req && !force_inst ? OWN_DATA : OWN_INST;
    grant = en_q && ready && (inst_req || data_req);
    cnt_d = !en_q || !ready ? cnt_q
          : !inst_req || winner == OWN_INST ? '0
          : cnt_q == CMAX ? cnt_q : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  always_comb begin
    winner = data_req ? OWN_DATA : OWN_INST;
    grant = en_q && ready && (inst_req || data_req);
  end
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one SRAM port between fetch and load/store, routing 1-cycle-late responses.
// Define MEM_ARB_STARVE_GUARD_EN to bound fetch starvation at STARVE_MAX consecutive losses.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        inst_req,
  input  logic [ADDR_W-1:0]           inst_addr,
  output logic                        inst_addr_ok,
  output logic                        inst_data_ok,
  output logic [DATA_W-1:0]           inst_rdata,
  input  logic                        data_req,
  input  logic                        data_wr,
  input  logic [ADDR_W-1:0]           data_addr,
  input  logic [DATA_W-1:0]           data_wdata,
  input  logic [strb_w(DATA_W)-1:0]   data_wstrb,
  output logic                        data_addr_ok,
  output logic                        data_data_ok,
  output logic [DATA_W-1:0]           data_rdata,
  input  logic                        sram_ready,
  output logic                        sram_en,
  output logic [strb_w(DATA_W)-1:0]   sram_wen,
  output logic [ADDR_W-1:0]           sram_addr,
  output logic [DATA_W-1:0]           sram_wdata,
  input  logic [DATA_W-1:0]           sram_rdata
);
  logic grant, data_win, inst_win;
  owner_e winner;
  logic resp_valid_q, resp_valid_d, resp_wr_q, resp_wr_d;
  owner_e resp_owner_q, resp_owner_d;
  mem_arb_grant #(.STARVE_MAX(STARVE_MAX)) u_grant (
    .clk      (clk),
    .resetn   (resetn),
    .inst_req (inst_req),
    .data_req (data_req),
    .ready    (sram_ready),
    .grant    (grant),
    .winner   (winner)
  );
  always_comb begin
    data_win = grant && winner == OWN_DATA;
    inst_win = grant && winner == OWN_INST;
    inst_addr_ok = inst_win;
    data_addr_ok = data_win;
    sram_en = grant;
    sram_addr = data_win ? data_addr : inst_win ? inst_addr : '0;
    sram_wdata = data_win ? data_wdata : '0;
    sram_wen = data_win && data_wr ? data_wstrb : '0;
    resp_valid_d = grant;
    resp_owner_d = winner;
    resp_wr_d = data_win && data_wr;
    inst_data_ok = resp_valid_q && resp_owner_q == OWN_INST;
    data_data_ok = resp_valid_q && resp_owner_q == OWN_DATA;
    inst_rdata = inst_data_ok ? sram_rdata : '0;
    // Stores still get data_ok but never expose read data.
    data_rdata = data_data_ok && !resp_wr_q ? sram_rdata : '0;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      resp_valid_q <= 1'b0;
      resp_owner_q <= OWN_INST;
      resp_wr_q <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_owner_q <= resp_owner_d;
      resp_wr_q <= resp_wr_d;
    end
endmodule
